// File: rtl/imm_ctrl_if.sv
// Datapath-facing bundle for the Mini-SRC control sequencer.
// The datapath drives IR/Stop. The sequencer drives the strobes, OP, Run and Illegal.
interface imm_ctrl_if;
  logic [31:0] IR;
  logic        Stop;
  logic PCout, MARin, Read, MDRin, IncPC;
  logic MDRout, IRin;
  logic Gra, Grb, Grc, Rin, Rout;
  logic Yin, Cout, ZHighin, ZLowin, ZLowout;
  logic [4:0]  OP;
  logic        Run;
  logic        Illegal;

  modport master (
    output IR, Stop,
    input  PCout, MARin, Read, MDRin, IncPC,
    input  MDRout, IRin, Gra, Grb, Grc, Rin, Rout,
    input  Yin, Cout, ZHighin, ZLowin, ZLowout,
    input  OP, Run, Illegal
  );

  modport slave (
    input  IR, Stop,
    output PCout, MARin, Read, MDRin, IncPC,
    output MDRout, IRin, Gra, Grb, Grc, Rin, Rout,
    output Yin, Cout, ZHighin, ZLowin, ZLowout,
    output OP, Run, Illegal
  );
endinterface

// File: rtl/imm_ctrl_unit.sv
// Mini-SRC control sequencer: fetch, ALU-immediate ops, nop and halt.
// Optional macro ALU_RR_EN adds the register-register add/sub/and/or ops.
module imm_ctrl_unit #(
  parameter int unsigned MEM_WAIT_CYCLES = 2,
  parameter logic [4:0]  ALU_OP_ADD = 5'b00001,
  parameter logic [4:0]  ALU_OP_SUB = 5'b00010,
  parameter logic [4:0]  ALU_OP_AND = 5'b00011,
  parameter logic [4:0]  ALU_OP_OR  = 5'b00100
) (
  input logic        Clock,
  input logic        Clear,
  imm_ctrl_if.slave  bus
);

  localparam int unsigned CW = $clog2(MEM_WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_WAIT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_PAUSE, S_HALT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [4:0]    op_q;
  logic          rr_q;

  logic [4:0] opc;
  logic       unused_ir;
  assign opc       = bus.IR[31:27];
  assign unused_ir = ^bus.IR[26:0];

  logic       is_imm, is_rr, is_nop, is_halt;
  logic [4:0] op_dec;

  always_comb begin
    is_imm  = 1'b0;
    is_rr   = 1'b0;
    is_nop  = 1'b0;
    is_halt = 1'b0;
    op_dec  = '0;
    case (opc)
      5'b01100: begin is_imm = 1'b1; op_dec = ALU_OP_ADD; end
      5'b01101: begin is_imm = 1'b1; op_dec = ALU_OP_AND; end
      5'b01110: begin is_imm = 1'b1; op_dec = ALU_OP_OR;  end
      5'b11010: is_nop  = 1'b1;
      5'b11011: is_halt = 1'b1;
`ifdef ALU_RR_EN
      5'b00011: begin is_rr = 1'b1; op_dec = ALU_OP_ADD; end
      5'b00100: begin is_rr = 1'b1; op_dec = ALU_OP_SUB; end
      5'b00101: begin is_rr = 1'b1; op_dec = ALU_OP_AND; end
      5'b00110: begin is_rr = 1'b1; op_dec = ALU_OP_OR;  end
`endif
      default: ;
    endcase
  end

  state_t boundary;
  assign boundary = bus.Stop ? S_PAUSE : S_T0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:   state_d = S_T0;
      S_T0:    if (cnt_q == CNT_LAST) state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3: begin
        if (is_halt)              state_d = S_HALT;
        else if (is_imm || is_rr) state_d = S_T4;
        else                      state_d = boundary;
      end
      S_T4:    state_d = S_T5;
      S_T5:    state_d = boundary;
      S_PAUSE: if (!bus.Stop) state_d = S_T0;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  // op class is captured in T3 so T4/T5 do not rely on IR staying put
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q <= S_RST;
      cnt_q   <= '0;
      op_q    <= '0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_T0 && state_d == S_T0) cnt_q <= cnt_q + 1'b1;
      else                                   cnt_q <= '0;
      if (state_q == S_T3) begin
        op_q <= op_dec;
        rr_q <= is_rr;
      end
    end
  end

  always_comb begin
    bus.PCout   = 1'b0;
    bus.MARin   = 1'b0;
    bus.Read    = 1'b0;
    bus.MDRin   = 1'b0;
    bus.IncPC   = 1'b0;
    bus.MDRout  = 1'b0;
    bus.IRin    = 1'b0;
    bus.Gra     = 1'b0;
    bus.Grb     = 1'b0;
    bus.Grc     = 1'b0;
    bus.Rin     = 1'b0;
    bus.Rout    = 1'b0;
    bus.Yin     = 1'b0;
    bus.Cout    = 1'b0;
    bus.ZHighin = 1'b0;
    bus.ZLowin  = 1'b0;
    bus.ZLowout = 1'b0;
    bus.OP      = '0;
    bus.Run     = 1'b0;
    bus.Illegal = 1'b0;
    case (state_q)
      S_T0: begin
        bus.Run   = 1'b1;
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.Read  = 1'b1;
        bus.MDRin = 1'b1;
      end
      S_T1: begin
        bus.Run   = 1'b1;
        bus.IncPC = 1'b1;
      end
      S_T2: begin
        bus.Run    = 1'b1;
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      S_T3: begin
        bus.Run = 1'b1;
        if (is_imm || is_rr) begin
          bus.Grb  = 1'b1;
          bus.Rout = 1'b1;
          bus.Yin  = 1'b1;
        end else if (!is_nop && !is_halt) begin
          bus.Illegal = 1'b1;
        end
      end
      S_T4: begin
        bus.Run     = 1'b1;
        bus.OP      = op_q;
        bus.ZHighin = 1'b1;
        bus.ZLowin  = 1'b1;
        if (rr_q) begin
          bus.Grc  = 1'b1;
          bus.Rout = 1'b1;
        end else begin
          bus.Cout = 1'b1;
        end
      end
      S_T5: begin
        bus.Run     = 1'b1;
        bus.OP      = op_q;
        bus.ZLowout = 1'b1;
        bus.Gra     = 1'b1;
        bus.Rin     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_imm_ctrl_unit.sv
// Directed bench for imm_ctrl_unit with hand-built expected strobe words.
// Word layout: 17 strobes, OP[4:0], Run, Illegal.
module tb_imm_ctrl_unit;

  logic Clock;
  logic Clear;
  imm_ctrl_if bus ();

  imm_ctrl_unit dut (
    .Clock (Clock),
    .Clear (Clear),
    .bus   (bus.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  localparam logic [23:0] PCOUT   = 24'(1) << 23;
  localparam logic [23:0] MARIN   = 24'(1) << 22;
  localparam logic [23:0] READ    = 24'(1) << 21;
  localparam logic [23:0] MDRIN   = 24'(1) << 20;
  localparam logic [23:0] INCPC   = 24'(1) << 19;
  localparam logic [23:0] MDROUT  = 24'(1) << 18;
  localparam logic [23:0] IRIN    = 24'(1) << 17;
  localparam logic [23:0] GRA     = 24'(1) << 16;
  localparam logic [23:0] GRB     = 24'(1) << 15;
  localparam logic [23:0] GRC     = 24'(1) << 14;
  localparam logic [23:0] RIN     = 24'(1) << 13;
  localparam logic [23:0] ROUT    = 24'(1) << 12;
  localparam logic [23:0] YIN     = 24'(1) << 11;
  localparam logic [23:0] COUT    = 24'(1) << 10;
  localparam logic [23:0] ZHIGHIN = 24'(1) << 9;
  localparam logic [23:0] ZLOWIN  = 24'(1) << 8;
  localparam logic [23:0] ZLOWOUT = 24'(1) << 7;
  localparam logic [23:0] RUN     = 24'(1) << 1;
  localparam logic [23:0] ILL     = 24'(1);

  localparam logic [23:0] E_T0 = PCOUT | MARIN | READ | MDRIN | RUN;
  localparam logic [23:0] E_T1 = INCPC | RUN;
  localparam logic [23:0] E_T2 = MDROUT | IRIN | RUN;
  localparam logic [23:0] E_T3 = GRB | ROUT | YIN | RUN;
  localparam logic [23:0] E_T5 = ZLOWOUT | GRA | RIN | RUN;

  logic [23:0] obs;
  assign obs = {bus.PCout, bus.MARin, bus.Read, bus.MDRin, bus.IncPC,
                bus.MDRout, bus.IRin, bus.Gra, bus.Grb, bus.Grc,
                bus.Rin, bus.Rout, bus.Yin, bus.Cout, bus.ZHighin,
                bus.ZLowin, bus.ZLowout, bus.OP, bus.Run, bus.Illegal};

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [23:0] got,
                     input logic [23:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %06h expected %06h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [23:0] opw(input logic [4:0] op);
    return {17'b0, op, 2'b0};
  endfunction

  // next edge must land in T0; leaves the DUT sitting in T5
  task automatic run_alu(input string tag, input logic [31:0] ir,
                         input logic [4:0] op, input bit rr,
                         input bit stop4);
    bus.IR = ir;
    tick(); chk({tag, ".t0a"}, obs, E_T0);
    tick(); chk({tag, ".t0b"}, obs, E_T0);
    tick(); chk({tag, ".t1"},  obs, E_T1);
    tick(); chk({tag, ".t2"},  obs, E_T2);
    tick(); chk({tag, ".t3"},  obs, E_T3);
    tick();
    if (rr) chk({tag, ".t4"}, obs, GRC | ROUT | ZHIGHIN | ZLOWIN | RUN | opw(op));
    else    chk({tag, ".t4"}, obs, COUT | ZHIGHIN | ZLOWIN | RUN | opw(op));
    if (stop4) bus.Stop = 1'b1;
    tick(); chk({tag, ".t5"}, obs, E_T5 | opw(op));
  endtask

  // nop / illegal / halt: next edge lands in T0, leaves DUT in T3
  task automatic run_short(input string tag, input logic [31:0] ir,
                           input logic [23:0] e3);
    bus.IR = ir;
    tick(); chk({tag, ".t0a"}, obs, E_T0);
    tick(); chk({tag, ".t0b"}, obs, E_T0);
    tick(); chk({tag, ".t1"},  obs, E_T1);
    tick(); chk({tag, ".t2"},  obs, E_T2);
    tick(); chk({tag, ".t3"},  obs, e3);
  endtask

  initial begin
    Clear   = 1'b1;
    bus.IR  = 32'h611FFFFD;
    bus.Stop = 1'b0;

    tick(); chk("rst0", obs, 24'h0);
    tick(); chk("rst1", obs, 24'h0);
    Clear = 1'b0;

    run_alu("addi", 32'h611FFFFD, 5'b00001, 1'b0, 1'b0);
    run_alu("andi", 32'h69180025, 5'b00011, 1'b0, 1'b0);
    run_alu("ori",  32'h71180025, 5'b00100, 1'b0, 1'b0);

    run_alu("addi_stop", 32'h611FFFFD, 5'b00001, 1'b0, 1'b1);
    tick(); chk("pause0", obs, 24'h0);
    tick(); chk("pause1", obs, 24'h0);
    bus.Stop = 1'b0;

    run_short("nop", 32'hD0000000, RUN);

`ifdef ALU_RR_EN
    run_alu("add_rr", 32'h18000000, 5'b00001, 1'b1, 1'b0);
    run_alu("sub_rr", 32'h20000000, 5'b00010, 1'b1, 1'b0);
    run_short("ill0", 32'h00000000, RUN | ILL);
`else
    run_short("add_ill", 32'h18000000, RUN | ILL);
    run_short("sub_ill", 32'h20000000, RUN | ILL);
`endif
    tick(); chk("ill_end", obs, E_T0);
    tick(); chk("ill_t0b", obs, E_T0);
    tick(); chk("ill_t1", obs, E_T1);
    tick(); chk("ill_t2", obs, E_T2);
    bus.IR = 32'hD8000000;
    tick(); chk("halt.t3", obs, RUN);

    bus.Stop = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(); chk($sformatf("halt%0d", i), obs, 24'h0);
    end
    bus.Stop = 1'b0;

    Clear = 1'b1;
    tick(); chk("clr_halt", obs, 24'h0);
    Clear = 1'b0;
    bus.IR = 32'h611FFFFD;
    tick(); chk("restart.t0a", obs, E_T0);
    tick(); chk("restart.t0b", obs, E_T0);
    tick(); chk("restart.t1", obs, E_T1);
    tick(); chk("restart.t2", obs, E_T2);
    tick(); chk("restart.t3", obs, E_T3);
    tick(); chk("restart.t4", obs, COUT | ZHIGHIN | ZLOWIN | RUN | opw(5'b00001));

    Clear = 1'b1;
    tick(); chk("abort", obs, 24'h0);
    Clear = 1'b0;
    tick(); chk("abort.t0", obs, E_T0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
